// File: rtl/cruise_speed_ctrl_pkg.sv
// Shared types and defaults for the cruise-control speed regulator.
// Holds the FSM state encoding and the default regulation limits.
package cruise_speed_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_CRUISE  = 2'd1,
      ST_STANDBY = 2'd2
   } cc_state_e;

   localparam logic [7:0]  DEF_MIN_SPEED  = 8'd30;
   localparam logic [7:0]  DEF_MAX_SPEED  = 8'd200;
   localparam logic [7:0]  DEF_HYST       = 8'd2;
   localparam logic [7:0]  DEF_STEP       = 8'd1;
   localparam logic [15:0] DEF_REPEAT_CYC = 16'd500;

   // Magnitude of speed - target from the add/sub result; Cout=0 means negative.
   function automatic logic [7:0] abs_err(input logic cout, input logic [7:0] sum);
      return cout ? sum : 8'(~sum + 8'd1);
   endfunction

endpackage

// File: rtl/cruise_speed_ctrl_if.sv
// Driver-side controls and regulator outputs of the cruise speed controller.
// The controlling side uses master; the regulator uses slave.
interface cruise_speed_ctrl_if;

   logic [7:0] speed;
   logic       set_btn;
   logic       resume_btn;
   logic       cancel_btn;
   logic       brake;
   logic       inc_btn;
   logic       dec_btn;
   logic       cruise_on;
   logic       standby;
   logic [7:0] target;
   logic       throttle_up;
   logic       throttle_down;
   logic [7:0] err_mag;

   modport master (
      output speed, set_btn, resume_btn, cancel_btn, brake, inc_btn, dec_btn,
      input  cruise_on, standby, target, throttle_up, throttle_down, err_mag
   );

   modport slave (
      input  speed, set_btn, resume_btn, cancel_btn, brake, inc_btn, dec_btn,
      output cruise_on, standby, target, throttle_up, throttle_down, err_mag
   );

endinterface

// File: rtl/cruise_speed_ctrl_addsub.sv
// Generic W-bit add/sub cell: select_i=0 gives a+b, select_i=1 gives a-b
// as a + ~b + 1, with the carry out exposed for magnitude/sign decisions.
module cruise_speed_ctrl_addsub #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         select_i,
   output logic [W-1:0] sum_o,
   output logic         cout_o
);

   logic [W:0] a_ext;
   logic [W:0] b_ext;
   logic [W:0] cin_ext;
   logic [W:0] res;

   always_comb begin
      a_ext   = {1'b0, a_i};
      b_ext   = {1'b0, b_i ^ {W{select_i}}};
      cin_ext = {{W{1'b0}}, select_i};
      res     = a_ext + b_ext + cin_ext;
      sum_o   = res[W-1:0];
      cout_o  = res[W];
   end

endmodule

// File: rtl/cruise_speed_ctrl.sv
// Cruise-control speed regulator: OFF/CRUISE/STANDBY FSM, target register with
// inc/dec auto-repeat and saturation, and registered hysteresis throttle requests.
module cruise_speed_ctrl
   import cruise_speed_ctrl_pkg::*;
#(
   parameter logic [7:0]  MIN_SPEED  = DEF_MIN_SPEED,
   parameter logic [7:0]  MAX_SPEED  = DEF_MAX_SPEED,
   parameter logic [7:0]  HYST       = DEF_HYST,
   parameter logic [7:0]  STEP       = DEF_STEP,
   parameter logic [15:0] REPEAT_CYC = DEF_REPEAT_CYC
) (
   input  logic                clk,
   input  logic                rst_n,
   cruise_speed_ctrl_if.slave  bus
);

   cc_state_e   state_q, state_d;
   logic [7:0]  target_q, target_d;
   logic        tgt_valid_q, tgt_valid_d;
   logic [15:0] rep_q, rep_d;
   logic        inc_q, dec_q;
   logic        up_q, up_d;
   logic        down_q, down_d;
   logic [7:0]  err_q, err_d;

   logic [7:0]  diff_sum;
   logic        diff_cout;
   logic        in_range;
   logic        step_inc;
   logic        step_dec;
   logic        btn_edge;

   cruise_speed_ctrl_addsub #(.W(8)) u_addsub (
      .a_i      (bus.speed),
      .b_i      (target_q),
      .select_i (1'b1),
      .sum_o    (diff_sum),
      .cout_o   (diff_cout)
   );

   assign in_range = (bus.speed >= MIN_SPEED) && (bus.speed <= MAX_SPEED);

   // Single-button hold: edge steps at once, then every REPEAT_CYC cycles.
   always_comb begin
      rep_d    = '0;
      step_inc = 1'b0;
      step_dec = 1'b0;
      btn_edge = 1'b0;
      if (bus.inc_btn ^ bus.dec_btn) begin
         btn_edge = bus.inc_btn ? ~inc_q : ~dec_q;
         if (btn_edge || (rep_q == REPEAT_CYC - 16'd1)) begin
            step_inc = bus.inc_btn;
            step_dec = bus.dec_btn;
         end else begin
            rep_d = rep_q + 16'd1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      tgt_valid_d = tgt_valid_q;
      if (bus.brake || bus.cancel_btn) begin
         if (state_q == ST_CRUISE) begin
            state_d = ST_STANDBY;
         end
      end else if (bus.set_btn && in_range) begin
         state_d     = ST_CRUISE;
         target_d    = bus.speed;
         tgt_valid_d = 1'b1;
      end else if (bus.resume_btn && (state_q == ST_STANDBY) && tgt_valid_q) begin
         state_d = ST_CRUISE;
      end else if (state_q == ST_CRUISE) begin
         if (step_inc) begin
            target_d = (target_q > MAX_SPEED - STEP) ? MAX_SPEED : target_q + STEP;
         end else if (step_dec) begin
            target_d = (target_q < MIN_SPEED + STEP) ? MIN_SPEED : target_q - STEP;
         end
      end
   end

   // Requests need CRUISE on both sides of the edge so they drop with the state.
   always_comb begin
      err_d  = abs_err(diff_cout, diff_sum);
      up_d   = 1'b0;
      down_d = 1'b0;
      if ((state_q == ST_CRUISE) && (state_d == ST_CRUISE) && (err_d > HYST)) begin
         up_d   = ~diff_cout;
         down_d = diff_cout;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_OFF;
         target_q    <= '0;
         tgt_valid_q <= 1'b0;
         rep_q       <= '0;
         inc_q       <= 1'b0;
         dec_q       <= 1'b0;
         up_q        <= 1'b0;
         down_q      <= 1'b0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         tgt_valid_q <= tgt_valid_d;
         rep_q       <= rep_d;
         inc_q       <= bus.inc_btn;
         dec_q       <= bus.dec_btn;
         up_q        <= up_d;
         down_q      <= down_d;
         err_q       <= err_d;
      end
   end

   assign bus.cruise_on     = (state_q == ST_CRUISE);
   assign bus.standby       = (state_q == ST_STANDBY);
   assign bus.target        = target_q;
   assign bus.throttle_up   = up_q;
   assign bus.throttle_down = down_q;
   assign bus.err_mag       = err_q;

endmodule

// File: tb/tb_cruise_speed_ctrl.sv
// Scoreboard bench for cruise_speed_ctrl: the driver queues hand-computed
// expected outputs tagged with the cycle they must appear in; a monitor checks them.
module tb_cruise_speed_ctrl;

   typedef struct {
      int          cyc;
      string       name;
      logic [19:0] v;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   total;
   int   bad;
   logic drv_done;
   exp_t sb_q[$];
   exp_t e;
   logic [19:0] act;

   cruise_speed_ctrl_if bus ();

   cruise_speed_ctrl #(.REPEAT_CYC(16'd4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Queue the outputs expected after the next edge, then take that edge.
   task automatic chk(input string nm, input logic on, input logic sb,
                      input logic [7:0] tgt, input logic up, input logic dn,
                      input logic [7:0] em);
      exp_t x;
      x.cyc  = cyc + 1;
      x.name = nm;
      x.v    = {on, sb, tgt, up, dn, em};
      sb_q.push_back(x);
      tick();
   endtask

   always @(negedge clk) begin
      if (cyc > 3000) begin
         bad = bad + 1;
         $display("FAIL timeout: cycle %0d reached with %0d pending, required drain", cyc, sb_q.size());
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
      while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
         e     = sb_q.pop_front();
         total = total + 1;
         act   = {bus.cruise_on, bus.standby, bus.target, bus.throttle_up,
                  bus.throttle_down, bus.err_mag};
         if (e.cyc != cyc) begin
            bad = bad + 1;
            $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
         end else if (act !== e.v) begin
            bad = bad + 1;
            $display("FAIL %s: got on=%0b sb=%0b tgt=%0d up=%0b dn=%0b err=%0d, exp on=%0b sb=%0b tgt=%0d up=%0b dn=%0b err=%0d",
                     e.name, act[19], act[18], act[17:10], act[9], act[8], act[7:0],
                     e.v[19], e.v[18], e.v[17:10], e.v[9], e.v[8], e.v[7:0]);
         end
      end
      if (rst_n === 1'b1) begin
         total = total + 1;
         if ((bus.throttle_up & bus.throttle_down) !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL excl: up=%0b dn=%0b at cycle %0d, required not both 1",
                     bus.throttle_up, bus.throttle_down, cyc);
         end
      end
      if (drv_done && sb_q.size() == 0) begin
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   logic [7:0] rep_tgt [10];
   logic [7:0] rep_em  [10];
   logic [7:0] dec_tgt [4];

   initial begin
      total = 0;
      bad   = 0;
      drv_done = 1'b0;
      rep_tgt = '{8'd199, 8'd199, 8'd199, 8'd199, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200};
      rep_em  = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
      dec_tgt = '{8'd31, 8'd31, 8'd31, 8'd30};
      rst_n = 1'b0;
      bus.speed = 8'd80;
      bus.set_btn = 1'b0;
      bus.resume_btn = 1'b0;
      bus.cancel_btn = 1'b0;
      bus.brake = 1'b0;
      bus.inc_btn = 1'b0;
      bus.dec_btn = 1'b0;
      tick();
      chk("t1_reset", 0, 0, 8'd0, 0, 0, 8'd0);

      rst_n = 1'b1; bus.set_btn = 1'b1;
      chk("t2_engage", 1, 0, 8'd80, 0, 0, 8'd80);
      bus.set_btn = 1'b0; bus.speed = 8'd77;
      chk("t2_up", 1, 0, 8'd80, 1, 0, 8'd3);
      bus.speed = 8'd83;
      chk("t2_down", 1, 0, 8'd80, 0, 1, 8'd3);
      bus.speed = 8'd81;
      chk("t2_band", 1, 0, 8'd80, 0, 0, 8'd1);
      bus.speed = 8'd78;
      chk("t2_hyst_lo", 1, 0, 8'd80, 0, 0, 8'd2);
      bus.speed = 8'd82;
      chk("t2_hyst_hi", 1, 0, 8'd80, 0, 0, 8'd2);

      bus.speed = 8'd77;
      chk("t3_pre", 1, 0, 8'd80, 1, 0, 8'd3);
      bus.brake = 1'b1;
      chk("t3_brake", 0, 1, 8'd80, 0, 0, 8'd3);
      bus.brake = 1'b0; bus.resume_btn = 1'b1;
      chk("t3_resume", 1, 0, 8'd80, 0, 0, 8'd3);
      bus.resume_btn = 1'b0;
      chk("t3_cruise", 1, 0, 8'd80, 1, 0, 8'd3);
      bus.cancel_btn = 1'b1;
      chk("t3_cancel", 0, 1, 8'd80, 0, 0, 8'd3);
      bus.cancel_btn = 1'b0; bus.inc_btn = 1'b1;
      chk("t3_sb_inc", 0, 1, 8'd80, 0, 0, 8'd3);
      bus.inc_btn = 1'b0; bus.resume_btn = 1'b1;
      chk("t3_resume2", 1, 0, 8'd80, 0, 0, 8'd3);

      bus.resume_btn = 1'b0; bus.speed = 8'd90; bus.set_btn = 1'b1; bus.brake = 1'b1;
      chk("t5_set_brake", 0, 1, 8'd80, 0, 0, 8'd10);
      bus.brake = 1'b0;
      chk("t5_sb_set", 1, 0, 8'd90, 0, 0, 8'd10);
      bus.set_btn = 1'b0;
      chk("t5_settle", 1, 0, 8'd90, 0, 0, 8'd0);
      bus.speed = 8'd210; bus.set_btn = 1'b1;
      chk("t5_set_oor", 1, 0, 8'd90, 0, 1, 8'd120);

      bus.speed = 8'd198;
      chk("t4_load", 1, 0, 8'd198, 0, 1, 8'd108);
      bus.set_btn = 1'b0; bus.inc_btn = 1'b1;
      for (int i = 0; i < 10; i++) chk("t4_rep", 1, 0, rep_tgt[i], 0, 0, rep_em[i]);
      bus.inc_btn = 1'b0; bus.speed = 8'd31; bus.set_btn = 1'b1;
      chk("t4_load_min", 1, 0, 8'd31, 1, 0, 8'd169);
      bus.set_btn = 1'b0; bus.inc_btn = 1'b1; bus.dec_btn = 1'b1;
      for (int i = 0; i < 5; i++) chk("t4_both", 1, 0, 8'd31, 0, 0, 8'd0);
      bus.inc_btn = 1'b0;
      for (int i = 0; i < 4; i++) chk("t4_dec_rep", 1, 0, dec_tgt[i], 0, 0, 8'd0);
      bus.dec_btn = 1'b0;
      chk("t4_dec_rel", 1, 0, 8'd30, 0, 0, 8'd1);
      bus.dec_btn = 1'b1;
      chk("t4_dec_floor", 1, 0, 8'd30, 0, 0, 8'd1);
      bus.dec_btn = 1'b0;

      rst_n = 1'b0;
      chk("t6_reset", 0, 0, 8'd0, 0, 0, 8'd0);
      rst_n = 1'b1; bus.resume_btn = 1'b1; bus.speed = 8'd80;
      chk("t6_resume", 0, 0, 8'd0, 0, 0, 8'd80);
      bus.resume_btn = 1'b0; bus.speed = 8'd20; bus.set_btn = 1'b1;
      chk("t5_low", 0, 0, 8'd0, 0, 0, 8'd20);
      bus.speed = 8'd201;
      chk("t5_high", 0, 0, 8'd0, 0, 0, 8'd201);
      bus.speed = 8'd29;
      chk("t5_below_min", 0, 0, 8'd0, 0, 0, 8'd29);
      bus.speed = 8'd30;
      chk("t5_min", 1, 0, 8'd30, 0, 0, 8'd30);
      bus.set_btn = 1'b0;
      tick();
      drv_done = 1'b1;
   end

endmodule
